// File: rtl/player_motion_ctl.sv
// player_motion_ctl
// Per-player motion controller. Turns button levels into a registered sprite
// position on the 1024x768 playfield, moving one pixel per move tick. It also
// resolves the platform-collision result, which is computed from this block's
// own xpos/ypos, into landing, head-bump, side push-back and falling.
//
// Ports:
//   clk        system clock
//   rst        synchronous reset, active-high
//   left       move-left button level
//   right      move-right button level
//   jump       jump button level
//   coll[1:0]  collision result for current position:
//              11 side, 10 standing on platform, 01 head hit, 00 none
//   xpos[9:0]  sprite left edge
//   ypos[9:0]  sprite top edge
//   on_ground  1 while the vertical FSM is in GROUND
//   falling    1 while the vertical FSM is in FALL
//
// Vertical state is visible outside as {on_ground, falling}:
// 10 GROUND, 00 JUMP, 01 FALL.
module player_motion_ctl #(
  parameter int WIDTH       = 48,
  parameter int HEIGHT      = 64,
  parameter int X_INIT      = 100,
  parameter int Y_INIT      = 600,
  parameter int MOVE_DIV    = 400000,
  parameter int JUMP_HEIGHT = 120
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       left,
  input  logic       right,
  input  logic       jump,
  input  logic [1:0] coll,
  output logic [9:0] xpos,
  output logic [9:0] ypos,
  output logic       on_ground,
  output logic       falling
);

  localparam int TCW = $clog2(MOVE_DIV);
  localparam int JCW = $clog2(JUMP_HEIGHT);

  localparam logic [TCW-1:0] TICK_LAST = TCW'(MOVE_DIV - 1);
  localparam logic [JCW-1:0] JUMP_LAST = JCW'(JUMP_HEIGHT - 1);
  localparam logic [9:0]     Y_FLOOR   = 10'(767 - HEIGHT);
  localparam logic [9:0]     X_MAX     = 10'(1023 - WIDTH);

  localparam logic [1:0] COLL_SIDE  = 2'b11;
  localparam logic [1:0] COLL_STAND = 2'b10;
  localparam logic [1:0] COLL_HEAD  = 2'b01;

  localparam logic [1:0] ST_GROUND = 2'd0;
  localparam logic [1:0] ST_JUMP   = 2'd1;
  localparam logic [1:0] ST_FALL   = 2'd2;

  logic [TCW-1:0] tick_cnt_q, tick_cnt_d;
  logic [JCW-1:0] jump_cnt_q, jump_cnt_d;
  logic [1:0]     state_q, state_d;
  logic [9:0]     xpos_q, xpos_d;
  logic [9:0]     ypos_q, ypos_d;
  logic           dir_right_q, dir_right_d;

  logic           tick;
  logic [10:0]    x_ext, x_dec, x_inc, x_mv;

  assign tick = (tick_cnt_q == TICK_LAST);

  always_comb begin
    tick_cnt_d  = tick ? '0 : tick_cnt_q + 1'b1;
    jump_cnt_d  = jump_cnt_q;
    state_d     = state_q;
    xpos_d      = xpos_q;
    ypos_d      = ypos_q;
    dir_right_d = dir_right_q;

    // 11-bit horizontal arithmetic; decrement saturates at 0 so the
    // lower clamp below sees a small value rather than a wrapped one.
    x_ext = {1'b0, xpos_q};
    x_dec = (xpos_q == 10'd0) ? 11'd0 : x_ext - 11'd1;
    x_inc = x_ext + 11'd1;
    x_mv  = x_ext;

    if (tick) begin
      // Horizontal: side contact pushes back against the last walking
      // direction and overrides the buttons for this tick.
      if (coll == COLL_SIDE) begin
        x_mv = dir_right_q ? x_dec : x_inc;
      end else if (left && !right) begin
        x_mv        = x_dec;
        dir_right_d = 1'b0;
      end else if (right && !left) begin
        x_mv        = x_inc;
        dir_right_d = 1'b1;
      end

      if (x_mv < 11'd1) begin
        xpos_d = 10'd1;
      end else if (x_mv > {1'b0, X_MAX}) begin
        xpos_d = X_MAX;
      end else begin
        xpos_d = x_mv[9:0];
      end

      // Vertical FSM; side contact has no effect here.
      case (state_q)
        ST_GROUND: begin
          if (jump) begin
            state_d    = ST_JUMP;
            jump_cnt_d = '0;
          end else if (coll != COLL_STAND && ypos_q != Y_FLOOR) begin
            state_d = ST_FALL;
          end
        end
        ST_JUMP: begin
          // The tick that ends the rise does not move; <=1 also keeps
          // ypos from wrapping if the sprite ever sits at row 0.
          if (coll == COLL_HEAD || jump_cnt_q == JUMP_LAST || ypos_q <= 10'd1) begin
            state_d = ST_FALL;
          end else begin
            ypos_d     = ypos_q - 10'd1;
            jump_cnt_d = jump_cnt_q + 1'b1;
          end
        end
        default: begin
          if (coll == COLL_STAND || ypos_q >= Y_FLOOR) begin
            state_d = ST_GROUND;
            if (ypos_q > Y_FLOOR) begin
              ypos_d = Y_FLOOR;
            end
          end else begin
            ypos_d = ypos_q + 10'd1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt_q  <= '0;
      jump_cnt_q  <= '0;
      state_q     <= ST_FALL;
      xpos_q      <= 10'(X_INIT);
      ypos_q      <= 10'(Y_INIT);
      dir_right_q <= 1'b1;
    end else begin
      tick_cnt_q  <= tick_cnt_d;
      jump_cnt_q  <= jump_cnt_d;
      state_q     <= state_d;
      xpos_q      <= xpos_d;
      ypos_q      <= ypos_d;
      dir_right_q <= dir_right_d;
    end
  end

  assign xpos      = xpos_q;
  assign ypos      = ypos_q;
  assign on_ground = (state_q == ST_GROUND);
  assign falling   = (state_q == ST_FALL);

endmodule

// File: tb/tb_player_motion_ctl.sv
// tb_player_motion_ctl
// Directed bench for player_motion_ctl with MOVE_DIV=4, Y_INIT=700,
// JUMP_HEIGHT=5. A table of per-tick {buttons, coll, expected x/y/state}
// records covers landing, walking, jump apex, head bump, platform landing,
// walk-off and side push; hand-written sequences cover reset mid-jump and
// the horizontal clamps. Every tick also checks that nothing moved on the
// non-tick edges before it.
module tb_player_motion_ctl;

  localparam int MOVE_DIV = 4;

  // Expected {on_ground, falling}
  localparam logic [1:0] S_G = 2'b10;
  localparam logic [1:0] S_J = 2'b00;
  localparam logic [1:0] S_F = 2'b01;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       left = 1'b0;
  logic       right = 1'b0;
  logic       jump = 1'b0;
  logic [1:0] coll = 2'b00;
  logic [9:0] xpos, ypos;
  logic       on_ground, falling;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [9:0] last_x = 10'd100;
  logic [9:0] last_y = 10'd700;
  logic [1:0] last_s = S_F;

  typedef struct {
    logic [2:0] btn;   // {left, right, jump}
    logic [1:0] c;
    logic [9:0] ex;
    logic [9:0] ey;
    logic [1:0] es;
  } vec_t;

  vec_t vecs[$];

  player_motion_ctl #(
    .WIDTH      (48),
    .HEIGHT     (64),
    .X_INIT     (100),
    .Y_INIT     (700),
    .MOVE_DIV   (MOVE_DIV),
    .JUMP_HEIGHT(5)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .left     (left),
    .right    (right),
    .jump     (jump),
    .coll     (coll),
    .xpos     (xpos),
    .ypos     (ypos),
    .on_ground(on_ground),
    .falling  (falling)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: sim time exceeded, tests_run=%0d", tests_run);
    $fatal(1, "simulation timeout");
  end

  task automatic check(input string nm, input logic [9:0] ex, input logic [9:0] ey,
                       input logic [1:0] es);
    tests_run++;
    if (xpos !== ex || ypos !== ey || {on_ground, falling} !== es) begin
      tests_failed++;
      $display("FAIL %s: got x=%0d y=%0d gf=%b, expected x=%0d y=%0d gf=%b",
               nm, xpos, ypos, {on_ground, falling}, ex, ey, es);
    end
  endtask

  // Drive inputs, check that the non-tick edges hold the previous state,
  // then check the result of the tick edge.
  task automatic do_tick(input string nm, input logic [2:0] btn, input logic [1:0] c,
                         input logic [9:0] ex, input logic [9:0] ey, input logic [1:0] es);
    {left, right, jump} = btn;
    coll = c;
    repeat (MOVE_DIV - 1) @(posedge clk);
    #1;
    check({nm, "_hold"}, last_x, last_y, last_s);
    @(posedge clk);
    #1;
    check(nm, ex, ey, es);
    last_x = ex;
    last_y = ey;
    last_s = es;
  endtask

  task automatic add(input logic [2:0] btn, input logic [1:0] c, input logic [9:0] ex,
                     input logic [9:0] ey, input logic [1:0] es);
    vec_t v;
    v.btn = btn;
    v.c   = c;
    v.ex  = ex;
    v.ey  = ey;
    v.es  = es;
    vecs.push_back(v);
  endtask

  initial begin
    logic [9:0] ex;

    // Reset (released right after an edge so ticks land every 4th edge)
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset", 10'd100, 10'd700, S_F);
    rst = 1'b0;

    // Landing from reset: 700 -> 703 over 3 ticks, then GROUND
    add(3'b000, 2'b00, 10'd100, 10'd701, S_F);
    add(3'b000, 2'b00, 10'd100, 10'd702, S_F);
    add(3'b000, 2'b00, 10'd100, 10'd703, S_F);
    add(3'b000, 2'b00, 10'd100, 10'd703, S_G);
    add(3'b000, 2'b00, 10'd100, 10'd703, S_G);
    // Walk: left, right, both
    add(3'b100, 2'b00, 10'd99,  10'd703, S_G);
    add(3'b010, 2'b00, 10'd100, 10'd703, S_G);
    add(3'b110, 2'b00, 10'd100, 10'd703, S_G);
    // Jump apex with JUMP_HEIGHT=5: four rises, then FALL without moving
    add(3'b001, 2'b00, 10'd100, 10'd703, S_J);
    add(3'b000, 2'b00, 10'd100, 10'd702, S_J);
    add(3'b000, 2'b00, 10'd100, 10'd701, S_J);
    add(3'b000, 2'b00, 10'd100, 10'd700, S_J);
    add(3'b000, 2'b00, 10'd100, 10'd699, S_J);
    add(3'b000, 2'b00, 10'd100, 10'd699, S_F);
    add(3'b000, 2'b00, 10'd100, 10'd700, S_F);
    add(3'b000, 2'b00, 10'd100, 10'd701, S_F);
    add(3'b000, 2'b00, 10'd100, 10'd702, S_F);
    add(3'b000, 2'b00, 10'd100, 10'd703, S_F);
    add(3'b000, 2'b00, 10'd100, 10'd703, S_G);
    // Head bump
    add(3'b001, 2'b00, 10'd100, 10'd703, S_J);
    add(3'b000, 2'b00, 10'd100, 10'd702, S_J);
    add(3'b000, 2'b01, 10'd100, 10'd702, S_F);
    add(3'b000, 2'b00, 10'd100, 10'd703, S_F);
    add(3'b000, 2'b00, 10'd100, 10'd703, S_G);
    // Platform landing mid-air, then walk-off
    add(3'b001, 2'b00, 10'd100, 10'd703, S_J);
    add(3'b000, 2'b00, 10'd100, 10'd702, S_J);
    add(3'b000, 2'b00, 10'd100, 10'd701, S_J);
    add(3'b000, 2'b00, 10'd100, 10'd700, S_J);
    add(3'b000, 2'b00, 10'd100, 10'd699, S_J);
    add(3'b000, 2'b00, 10'd100, 10'd699, S_F);
    add(3'b000, 2'b00, 10'd100, 10'd700, S_F);
    add(3'b000, 2'b10, 10'd100, 10'd700, S_G);
    add(3'b000, 2'b10, 10'd100, 10'd700, S_G);
    add(3'b000, 2'b00, 10'd100, 10'd700, S_F);
    add(3'b000, 2'b00, 10'd100, 10'd701, S_F);
    add(3'b000, 2'b00, 10'd100, 10'd702, S_F);
    add(3'b000, 2'b00, 10'd100, 10'd703, S_F);
    add(3'b000, 2'b00, 10'd100, 10'd703, S_G);
    // Diagonal jump, then side push-back against last_dir=right
    add(3'b011, 2'b00, 10'd101, 10'd703, S_J);
    add(3'b010, 2'b00, 10'd102, 10'd702, S_J);
    add(3'b010, 2'b11, 10'd101, 10'd701, S_J);
    add(3'b100, 2'b11, 10'd100, 10'd700, S_J);

    for (int i = 0; i < vecs.size(); i++) begin
      do_tick($sformatf("vec%0d", i), vecs[i].btn, vecs[i].c, vecs[i].ex, vecs[i].ey,
              vecs[i].es);
    end

    // Reset mid-jump (inputs still active) wins on the next edge
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_mid_jump", 10'd100, 10'd700, S_F);
    rst    = 1'b0;
    last_x = 10'd100;
    last_y = 10'd700;
    last_s = S_F;

    do_tick("settle1", 3'b000, 2'b00, 10'd100, 10'd701, S_F);
    do_tick("settle2", 3'b000, 2'b00, 10'd100, 10'd702, S_F);
    do_tick("settle3", 3'b000, 2'b00, 10'd100, 10'd703, S_F);
    do_tick("settle4", 3'b000, 2'b00, 10'd100, 10'd703, S_G);

    // Left clamp at 1
    ex = 10'd100;
    while (ex > 10'd3) begin
      ex = ex - 10'd1;
      do_tick($sformatf("walk_l_%0d", ex), 3'b100, 2'b00, ex, 10'd703, S_G);
    end
    do_tick("clamp_l_2", 3'b100, 2'b00, 10'd2, 10'd703, S_G);
    do_tick("clamp_l_1", 3'b100, 2'b00, 10'd1, 10'd703, S_G);
    do_tick("clamp_l_hold", 3'b100, 2'b00, 10'd1, 10'd703, S_G);

    // Right clamp at 1023-48=975
    ex = 10'd1;
    while (ex < 10'd974) begin
      ex = ex + 10'd1;
      do_tick($sformatf("walk_r_%0d", ex), 3'b010, 2'b00, ex, 10'd703, S_G);
    end
    do_tick("clamp_r_975", 3'b010, 2'b00, 10'd975, 10'd703, S_G);
    do_tick("clamp_r_hold", 3'b010, 2'b00, 10'd975, 10'd703, S_G);
    do_tick("both_at_max", 3'b110, 2'b00, 10'd975, 10'd703, S_G);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
